// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and sizes for the register-file write-back arbiter.
//   RF_AW/RF_DW/RF_BEW : register index, data and byte-enable widths
//   wb_req_t           : one buffered write (register, data, byte enables)
//   grant_t            : which requester won the write port last
package rf_wb_pkg;

    localparam int RF_AW  = 5;
    localparam int RF_DW  = 32;
    localparam int RF_BEW = 4;

    typedef struct packed {
        logic [RF_AW-1:0]  wr;
        logic [RF_DW-1:0]  wd;
        logic [RF_BEW-1:0] be;
    } wb_req_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry synchronous FIFO of write-back requests.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers/count only)
//   push, din       enqueue din at posedge (ignored when full)
//   pop, dout       dout is the head entry; pop removes it at posedge (ignored when empty)
//   full, empty     occupancy flags from current state
//   wr_mask         (RF_PENDING_EN only) one bit per register targeted by a valid entry
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  wb_req_t     din,
    input  logic        pop,
    output wb_req_t     dout,
    output logic        full,
    output logic        empty
`ifdef RF_PENDING_EN
    ,
    output logic [31:0] wr_mask
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity lives in count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

`ifdef RF_PENDING_EN
    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(AW'(i) - rptr) < count) wr_mask[mem[i].wr] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one byte-enabled register-file write port between requester A
// (ALU pipe) and requester B (load/mul-div). Each requester has a DEPTH-entry buffer;
// a round-robin grant drains one entry per cycle into registered reg_we/WR/WD.
// Optional feature macro: RF_PENDING_EN adds pending[31:0], a per-register
// write-back scoreboard (bit 0 always 0).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   a_valid/a_ready/a_wr/a_wd/a_be  requester A handshake and write request
//   b_valid/b_ready/b_wr/b_wd/b_be  requester B handshake and write request
//   reg_we, WR, WD                  registered register-file write port
//   busy                            any buffer non-empty or a write in the output stage
//   pending                         (RF_PENDING_EN) registers with an outstanding write
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [RF_AW-1:0]  a_wr,
    input  logic [RF_DW-1:0]  a_wd,
    input  logic [RF_BEW-1:0] a_be,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [RF_AW-1:0]  b_wr,
    input  logic [RF_DW-1:0]  b_wd,
    input  logic [RF_BEW-1:0] b_be,
    output logic [RF_BEW-1:0] reg_we,
    output logic [RF_AW-1:0]  WR,
    output logic [RF_DW-1:0]  WD,
    output logic              busy
`ifdef RF_PENDING_EN
    ,
    output logic [31:0]       pending
`endif
);

    wb_req_t a_req, b_req, a_head, b_head;
    logic    a_full, a_empty, b_full, b_empty;
    logic    a_push, b_push;
    logic    gnt_a, gnt_b;
    grant_t  last_grant;
`ifdef RF_PENDING_EN
    logic [31:0] a_mask, b_mask;
`endif

    // Ready reflects current occupancy only, so a pop never frees a slot in the same cycle.
    assign a_ready = ~a_full;
    assign b_ready = ~b_full;

    // Writes to x0 or with no byte enabled are accepted but have no effect, so drop them here.
    assign a_push = a_valid & a_ready & (a_wr != '0) & (a_be != '0);
    assign b_push = b_valid & b_ready & (b_wr != '0) & (b_be != '0);

    assign a_req = '{wr: a_wr, wd: a_wd, be: a_be};
    assign b_req = '{wr: b_wr, wd: b_wd, be: b_be};

    // ---- stage 0: per-requester buffers ----
    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push    (a_push),
        .din     (a_req),
        .pop     (gnt_a),
        .dout    (a_head),
        .full    (a_full),
        .empty   (a_empty)
`ifdef RF_PENDING_EN
        ,
        .wr_mask (a_mask)
`endif
    );

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push    (b_push),
        .din     (b_req),
        .pop     (gnt_b),
        .dout    (b_head),
        .full    (b_full),
        .empty   (b_empty)
`ifdef RF_PENDING_EN
        ,
        .wr_mask (b_mask)
`endif
    );

    // Round robin: on contention the requester that did not win last time goes.
    always_comb begin
        gnt_a = ~a_empty & (b_empty | (last_grant == GNT_B));
        gnt_b = ~b_empty & ~gnt_a;
    end

    // ---- stage 1: registered write port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we     <= '0;
            WR         <= '0;
            WD         <= '0;
            last_grant <= GNT_B;
        end else if (gnt_a) begin
            reg_we     <= a_head.be;
            WR         <= a_head.wr;
            WD         <= a_head.wd;
            last_grant <= GNT_A;
        end else if (gnt_b) begin
            reg_we     <= b_head.be;
            WR         <= b_head.wr;
            WD         <= b_head.wd;
            last_grant <= GNT_B;
        end else begin
            reg_we     <= '0;
        end
    end

    assign busy = ~a_empty | ~b_empty | (reg_we != '0);

`ifdef RF_PENDING_EN
    always_comb begin
        pending = a_mask | b_mask;
        if (reg_we != '0) pending[WR] = 1'b1;
        pending[0] = 1'b0;
    end
`endif

endmodule
